byte_serial_sub: RTL and testbench
==================================

// Module: byte_serial_sub
// PURPOSE
//  Byte-serial multi-byte subtractor: the subtract-direction counterpart of the team's 8-bit
//  carry-lookahead adder. Computes D = A - B - bin over NBYTES-byte operands streamed
//  LSB-byte first, one byte pair per accepted beat. Borrow is registered between beats.
//  Each byte uses an 8-bit borrow-lookahead stage (generate = ~a&b, propagate = ~(a^b)).
//  Sits between operand FIFOs and a result sink; both sides use valid/ready.
// PARAMETERS
//  NBYTES  4  operand length in bytes (>=1); beats per operation
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  clr         in   1  synchronous abort/clear, highest priority after rst_n
//  in_valid    in   1  operand byte pair valid
//  in_ready    out  1  block accepts a beat this cycle
//  in_a        in   8  minuend byte
//  in_b        in   8  subtrahend byte
//  bin         in   1  borrow-in; sampled only on beat 0 of an operation
//  out_valid   out  1  result byte valid
//  out_ready   in   1  sink accepts result byte
//  out_d       out  8  difference byte
//  out_last    out  1  marks byte NBYTES-1 of an operation
//  out_borrow  out  1  final borrow-out; valid only with out_last
//  out_zero    out  1  all NBYTES difference bytes zero; valid only with out_last
//  out_ovf     out  1  signed overflow of the full-width result; valid only with out_last
// BEHAVIOUR
//  - Reset (rst_n=0): out_valid, out_d, out_last, out_borrow, out_zero, out_ovf = 0;
//    beat counter = 0; borrow register = 0; zero accumulator = 1; FSM = IDLE.
//    in_ready = !out_valid || out_ready (combinational), so in_ready = 1 from reset.
//  - Accept: in_valid && in_ready. Only accepted beats advance state.
//  - Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N.
//    The output register holds until out_valid && out_ready. Full throughput is
//    1 beat/cycle when out_ready stays high.
//  - Per beat: bi = (cnt==0) ? bin : borrow_reg.
//    d = in_a - in_b - bi (mod 256), computed with 8-bit borrow lookahead.
//    bo = borrow out of bit 7. borrow_reg <= bo.
//  - FSM: IDLE (cnt=0) -> RUN on accept when NBYTES>1.
//    RUN: cnt increments per accept. RUN -> IDLE on accept of beat NBYTES-1 (cnt wraps to 0).
//    With NBYTES=1 the FSM stays IDLE and every beat is last.
//  - Zero accumulator: cleared to 1 at beat 0, then zacc &= (d==0).
//    out_zero = zacc including the current byte.
//  - Last beat (cnt==NBYTES-1): out_last=1, out_borrow=bo, out_ovf=(a7^b7)&(d7^a7).
//    On non-last beats out_last, out_borrow, out_zero and out_ovf are 0.
//  - Backpressure: while out_valid && !out_ready, in_ready=0.
//    out_d and flags stay stable; no beat is dropped or duplicated.
//  - clr=1: next edge forces out_valid=0, cnt=0, borrow_reg=0, zacc=1, FSM=IDLE.
//    in_ready=0 during a clr cycle, so no beat is accepted. A pending output byte is discarded.
//  - rst_n low mid-operation: immediate return to reset values, independent of clk.
//    The next accepted beat is treated as beat 0.
//  - No combinational path from in_* to out_*. out_ready -> in_ready is the only comb path.
// TESTING (NBYTES=4; bytes listed LSB first)
//  1. A=0x00000001, B=0x00000002, bin=0 -> out_d FF,FF,FF,FF; last: borrow=1, zero=0, ovf=0.
//  2. A=0x80000000, B=0x00000001 -> FF,FF,FF,7F; borrow=0, ovf=1, zero=0.
//     A=0x12345678, B=0x12345678 -> 00x4; zero=1, borrow=0, ovf=0.
//  3. A=0, B=0, bin=1 -> FF,FF,FF,FF, borrow=1; then immediate next op A=5, B=3, bin=0
//     -> 02,00,00,00. Proves bin is used only on beat 0 and borrow_reg is not carried over.
//  4. out_ready=0 for 3 cycles after beat 1 -> in_ready=0, out_d held stable;
//     all 4 bytes delivered in order, back-to-back throughput restored afterwards.
//  5. clr after 2 accepted beats, then a fresh op A=0x00000100, B=0x00000001
//     -> FF,00,00,00, borrow=0. Same check with rst_n pulsed mid-op: outputs 0 asynchronously.
//  6. 10k random operands/bin with random valid/ready stalls, NBYTES=1 and 4
//     -> every byte and flag matches a reference model of A-B-bin.

Source files
------------

// File: rtl/byte_serial_sub_if.sv
// Valid/ready bus of the byte-serial subtractor: operand side in, result side out.
// The slave modport is the subtractor; master is its FIFO/sink environment.
interface byte_serial_sub_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;
  logic       out_last;
  logic       out_borrow;
  logic       out_zero;
  logic       out_ovf;

  modport master (
    output in_valid, in_a, in_b, bin, out_ready,
    input  in_ready, out_valid, out_d, out_last, out_borrow, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, bin, out_ready,
    output in_ready, out_valid, out_d, out_last, out_borrow, out_zero, out_ovf
  );
endinterface

// File: rtl/byte_serial_sub.sv
// Byte-serial D = A - B - bin over NBYTES-byte operands, LSB byte first, one byte per beat.
// Borrow is registered between beats; the result byte is registered with a 1-cycle latency.
module byte_serial_sub #(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  byte_serial_sub_if.slave   bus
);

  localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q;
  logic          zacc_q;

  logic          accept;
  logic          is_first;
  logic          is_last;
  logic          bi;
  logic          bo;
  logic [7:0]    d;
  logic          zacc_cur;
  logic          ovf;

  // The sink's ready is the only combinational path through the block.
  assign bus.in_ready = !clr && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_first = (state_q == IDLE);
  assign is_last  = (cnt_q == LAST);
  assign bi       = is_first ? bus.bin : borrow_q;

  // 8-bit borrow lookahead: borrow into bit i+1 is g[i] | p[i] & borrow into bit i.
  always_comb begin
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = ~bus.in_a & bus.in_b;
    p    = ~(bus.in_a ^ bus.in_b);
    c    = '0;
    c[0] = bi;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    d  = bus.in_a ^ bus.in_b ^ c[7:0];
    bo = c[8];
  end

  assign zacc_cur = (is_first | zacc_q) & (d == 8'h00);
  assign ovf      = (bus.in_a[7] ^ bus.in_b[7]) & (d[7] ^ bus.in_a[7]);

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_q       <= 1'b0;
      zacc_q         <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_d      <= 8'h00;
      bus.out_last   <= 1'b0;
      bus.out_borrow <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_ovf    <= 1'b0;
    end else if (clr) begin
      borrow_q      <= 1'b0;
      zacc_q        <= 1'b1;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      borrow_q       <= bo;
      zacc_q         <= zacc_cur;
      bus.out_valid  <= 1'b1;
      bus.out_d      <= d;
      bus.out_last   <= is_last;
      bus.out_borrow <= is_last & bo;
      bus.out_zero   <= is_last & zacc_cur;
      bus.out_ovf    <= is_last & ovf;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_serial_sub.sv
// Bench for byte_serial_sub with NBYTES=4 and NBYTES=1 instances; results are compared
// against a whole-operand arithmetic model (A - B - bin on wide integers) split into bytes.
module tb_byte_serial_sub;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr4  = 1'b0;
  logic clr1  = 1'b0;

  always #5 clk = ~clk;

  byte_serial_sub_if if4 ();
  byte_serial_sub_if if1 ();

  byte_serial_sub #(.NBYTES(4)) u4 (.clk(clk), .rst_n(rst_n), .clr(clr4), .bus(if4.slave));
  byte_serial_sub #(.NBYTES(1)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr1), .bus(if1.slave));

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit   mon4 = 1'b1, mon1 = 1'b1;
  bit   rnd4 = 1'b0, rnd1 = 1'b0;
  logic man4 = 1'b1, man1 = 1'b1;
  logic rr4  = 1'b1, rr1  = 1'b1;

  assign if4.out_ready = rnd4 ? rr4 : man4;
  assign if1.out_ready = rnd1 ? rr1 : man1;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rr4 = ($urandom_range(0, 3) != 0);
    rr1 = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result sink monitors: each handshake pops one expected byte {d,last,borrow,zero,ovf}.
  always @(negedge clk) begin
    if (mon4 && rst_n && if4.out_valid && if4.out_ready) begin
      check("n4 byte expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check("n4 byte", 32'({if4.out_d, if4.out_last, if4.out_borrow, if4.out_zero, if4.out_ovf}),
              32'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (mon1 && rst_n && if1.out_valid && if1.out_ready) begin
      check("n1 byte expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("n1 byte", 32'({if1.out_d, if1.out_last, if1.out_borrow, if1.out_zero, if1.out_ovf}),
              32'(e1));
      end
    end
  end

  // Reference model: full-width subtraction, then split into LSB-first bytes.
  task automatic push_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [63:0] mask, av, bv, dd;
    logic        brw, z, ov;
    int          msb;
    exp_t        e;
    mask = (64'd1 << (8 * n)) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = {32'd0, b} & mask;
    dd   = (av - bv - {63'd0, bi}) & mask;
    brw  = (av < bv + {63'd0, bi});
    z    = (dd == 64'd0);
    msb  = 8 * n - 1;
    ov   = (av[msb] ^ bv[msb]) & (dd[msb] ^ av[msb]);
    for (int i = 0; i < n; i++) begin
      e.d      = dd[8*i +: 8];
      e.last   = (i == n - 1);
      e.borrow = e.last & brw;
      e.zero   = e.last & z;
      e.ovf    = e.last & ov;
      if (n == 4) q4.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic send_beat(input int n, input logic [7:0] a, input logic [7:0] b, input logic bi);
    int   t;
    logic rdy;
    if (n == 4) begin
      if4.in_valid = 1'b1; if4.in_a = a; if4.in_b = b; if4.bin = bi;
    end else begin
      if1.in_valid = 1'b1; if1.in_a = a; if1.in_b = b; if1.bin = bi;
    end
    t = 0;
    forever begin
      @(negedge clk);
      rdy = (n == 4) ? if4.in_ready : if1.in_ready;
      if (rdy) break;
      t++;
      if (t > 200) break;
    end
    check("accept within budget", 32'(t <= 200), 32'd1);
    @(posedge clk);
    #1;
    if (n == 4) if4.in_valid = 1'b0;
    else        if1.in_valid = 1'b0;
  endtask

  task automatic send_op(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic bi, input bit stall);
    push_op(n, a, b, bi);
    for (int i = 0; i < n; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      // bin on later beats is junk on purpose: it must be ignored.
      send_beat(n, a[8*i +: 8], b[8*i +: 8], (i == 0) ? bi : 1'($urandom_range(0, 1)));
    end
  endtask

  logic [31:0] ra, rb;
  int          t0;

  initial begin
    if4.in_valid = 1'b0; if4.in_a = 8'h00; if4.in_b = 8'h00; if4.bin = 1'b0;
    if1.in_valid = 1'b0; if1.in_a = 8'h00; if1.in_b = 8'h00; if1.bin = 1'b0;

    // Reset state
    #3;
    check("reset out_valid", 32'(if4.out_valid), 32'd0);
    check("reset out_d", 32'(if4.out_d), 32'd0);
    check("reset flags", 32'({if4.out_last, if4.out_borrow, if4.out_zero, if4.out_ovf}), 32'd0);
    check("reset in_ready", 32'(if4.in_ready), 32'd1);
    check("reset n1 out_valid", 32'(if1.out_valid), 32'd0);
    check("reset n1 in_ready", 32'(if1.in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed operands
    send_op(4, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    send_op(4, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    send_op(4, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    send_op(4, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    send_op(4, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("drain directed", 32'(q4.size()), 32'd0);

    // Backpressure after beat 1
    ra = $urandom; rb = $urandom;
    push_op(4, ra, rb, 1'b1);
    send_beat(4, ra[7:0], rb[7:0], 1'b1);
    send_beat(4, ra[15:8], rb[15:8], 1'b0);
    man4 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall in_ready", 32'(if4.in_ready), 32'd0);
      check("stall out_valid", 32'(if4.out_valid), 32'd1);
      check("stall out_d held", 32'(if4.out_d), 32'(q4[0].d));
    end
    @(posedge clk);
    #1;
    man4 = 1'b1;
    send_beat(4, ra[23:16], rb[23:16], 1'b0);
    send_beat(4, ra[31:24], rb[31:24], 1'b0);
    t0 = cyc;
    send_op(4, $urandom, $urandom, 1'b0, 1'b0);
    check("back-to-back cycles", 32'(cyc - t0), 32'd4);

    // clr after two accepted beats discards the operation
    @(posedge clk); #1;
    mon4 = 1'b0;
    send_beat(4, 8'h3c, 8'h5a, 1'b1);
    send_beat(4, 8'h77, 8'h11, 1'b0);
    clr4 = 1'b1;
    if4.in_valid = 1'b1; if4.in_a = 8'hee; if4.in_b = 8'h01;
    @(negedge clk);
    check("clr in_ready", 32'(if4.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr4 = 1'b0;
    if4.in_valid = 1'b0;
    check("clr out_valid", 32'(if4.out_valid), 32'd0);
    q4.delete();
    mon4 = 1'b1;
    send_op(4, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    mon4 = 1'b0;
    send_beat(4, 8'hab, 8'h01, 1'b0);
    send_beat(4, 8'hcd, 8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(if4.out_valid), 32'd0);
    check("async rst out_d", 32'(if4.out_d), 32'd0);
    check("async rst out_last", 32'(if4.out_last), 32'd0);
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
    q4.delete();
    mon4 = 1'b1;
    send_op(4, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);
    send_op(4, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

    // Random operands with valid and ready stalls
    rnd4 = 1'b1;
    repeat (3000) send_op(4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    rnd1 = 1'b1;
    repeat (7000) send_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    rnd4 = 1'b0;
    rnd1 = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("final drain n4", 32'(q4.size()), 32'd0);
    check("final drain n1", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
